// File: rtl/l2_lru_pkg.sv
// Shared tree pseudo-LRU types and helpers for the L2 replacement state.
// Trees are heap-ordered (node i -> children 2i+1 / 2i+2); bit 0 = LRU side left.
// Types are sized for the largest supported associativity (16 ways). The
// functions take the real way count and ignore the unused upper bits.
package l2_lru_pkg;

  localparam int unsigned MAX_WAYS   = 16;
  localparam int unsigned MAX_LEVELS = 4;

  typedef logic [MAX_WAYS-2:0]   tree_t;
  typedef logic [MAX_WAYS-1:0]   way_t;
  typedef logic [MAX_LEVELS-1:0] idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } zero_t;

  // Number of tree levels, i.e. log2 of the associativity.
  function automatic int unsigned num_levels(int unsigned num_ways);
    int unsigned lv;
    lv = 0;
    for (int unsigned i = 1; i <= MAX_LEVELS; i++) begin
      if ((32'd1 << i) <= num_ways) lv = i;
    end
    return lv;
  endfunction

  // Index of the lowest set bit; a multi-hot vector resolves to its lowest way.
  function automatic idx_t onehot_to_idx(way_t way);
    idx_t idx;
    logic hit;
    way_t m;
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      m = way >> i;
      if (m[0] && !hit) begin
        idx = idx_t'(i);
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

  // Lowest-indexed zero bit among the first num_ways bits.
  function automatic zero_t lowest_zero(way_t vec, int unsigned num_ways);
    zero_t r;
    way_t  m;
    r = '0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      m = vec >> i;
      if (i < num_ways && !m[0] && !r.found) begin
        r.found = 1'b1;
        r.idx   = idx_t'(i);
      end
    end
    return r;
  endfunction

  // Points every node on the path to way_idx away from that way.
  function automatic tree_t plru_touch(tree_t tree, idx_t way_idx, int unsigned num_ways);
    tree_t       t;
    logic [3:0]  node;
    idx_t        sh;
    logic        dir;
    int unsigned levels;
    t      = tree;
    node   = '0;
    levels = num_levels(num_ways);
    for (int unsigned lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        sh      = way_idx >> (levels - 1 - lvl);
        dir     = sh[0];
        t[node] = ~dir;
        node    = {node[2:0], 1'b0} + (dir ? 4'd2 : 4'd1);
      end
    end
    return t;
  endfunction

  // True when every way whose index prefix (above 'shift' bits) equals target
  // is excluded.
  function automatic logic subtree_excluded(way_t mask, idx_t target, int unsigned shift,
                                            int unsigned num_ways);
    logic all_ex;
    way_t m;
    idx_t w_idx;
    all_ex = 1'b1;
    for (int unsigned w = 0; w < MAX_WAYS; w++) begin
      m     = mask >> w;
      w_idx = idx_t'(w);
      if (w < num_ways && (w_idx >> shift) == target && !m[0]) all_ex = 1'b0;
    end
    return all_ex;
  endfunction

  // Follows the tree bits from the root, steering around fully excluded subtrees.
  function automatic idx_t plru_walk(tree_t tree, way_t exclude_mask, int unsigned num_ways);
    logic [3:0]  node;
    idx_t        p;
    logic        dir;
    int unsigned levels;
    node   = '0;
    p      = '0;
    levels = num_levels(num_ways);
    for (int unsigned lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        dir = tree[node];
        if (subtree_excluded(exclude_mask, {p[MAX_LEVELS-2:0], dir}, levels - 1 - lvl, num_ways))
          dir = ~dir;
        p    = {p[MAX_LEVELS-2:0], dir};
        node = {node[2:0], 1'b0} + (dir ? 4'd2 : 4'd1);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational update and victim selection for a single PLRU tree.
// Victim: lowest invalid non-excluded way, else tree walk avoiding excluded ways.
module plru_tree_logic
  import l2_lru_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 8
) (
  input  logic [NUM_WAYS-2:0]         tree_i,
  input  logic                        touch_en_i,
  input  logic [NUM_WAYS-1:0]         touch_way_i,
  input  logic [NUM_WAYS-1:0]         valid_i,
  input  logic [NUM_WAYS-1:0]         excl_i,
  output logic [NUM_WAYS-2:0]         tree_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_idx_o
);

  localparam int unsigned TREE_W = NUM_WAYS - 1;
  localparam int unsigned IDX_W  = $clog2(NUM_WAYS);

  zero_t z;

  // Touched tree and selected victim for the presented tree.
  always_comb begin
    tree_o = TREE_W'((touch_en_i && (|touch_way_i))
                     ? plru_touch(tree_t'(tree_i), onehot_to_idx(way_t'(touch_way_i)), NUM_WAYS)
                     : tree_t'(tree_i));
    // Excluded ways are treated as valid so they never win invalid priority.
    z = lowest_zero(way_t'(valid_i | excl_i), NUM_WAYS);
    victim_idx_o = IDX_W'(z.found ? z.idx
                                  : plru_walk(tree_t'(tree_i), way_t'(excl_i), NUM_WAYS));
  end

endmodule

// File: rtl/plru_set_array.sv
// Per-set tree pseudo-LRU state for the L2 cache with a registered victim lookup.
// Optional feature: define LRU_WAY_LOCK_EN to add lock_mask / all_locked.
module plru_set_array
  import l2_lru_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 8,
  parameter  int unsigned NUM_SETS = 32,
  localparam int unsigned SET_W    = $clog2(NUM_SETS),
  localparam int unsigned IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd_valid,
  input  logic [SET_W-1:0]    upd_set,
  input  logic [NUM_WAYS-1:0] upd_way,
  input  logic                lkp_valid,
  input  logic [SET_W-1:0]    lkp_set,
  input  logic [NUM_WAYS-1:0] lkp_way_valid,
`ifdef LRU_WAY_LOCK_EN
  input  logic [NUM_WAYS-1:0] lock_mask,
  output logic                all_locked,
`endif
  output logic                victim_valid,
  output logic [NUM_WAYS-1:0] victim_way,
  output logic [IDX_W-1:0]    victim_idx
);

  logic [NUM_WAYS-2:0] trees_q [NUM_SETS];

  logic [NUM_WAYS-2:0] upd_tree;
  logic [NUM_WAYS-2:0] lkp_tree;
  logic [IDX_W-1:0]    lkp_idx;
  logic [NUM_WAYS-1:0] excl_eff;
  logic [NUM_WAYS-1:0] victim_way_d;
  logic                all_locked_d;

  logic                victim_valid_q;
  logic [NUM_WAYS-1:0] victim_way_q;
  logic [IDX_W-1:0]    victim_idx_q;
  logic                all_locked_q;

  logic [IDX_W-1:0]    unused_upd_victim;
  logic [NUM_WAYS-2:0] unused_lkp_tree;

  // Update path: touched version of the addressed set's tree.
  plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_upd (
    .tree_i       (trees_q[upd_set]),
    .touch_en_i   (upd_valid),
    .touch_way_i  (upd_way),
    .valid_i      ('1),
    .excl_i       ('0),
    .tree_o       (upd_tree),
    .victim_idx_o (unused_upd_victim)
  );

  // Same-set update bypasses into the lookup so it sees the post-update tree.
  always_comb begin
    lkp_tree = trees_q[lkp_set];
    if (upd_valid && (upd_set == lkp_set)) lkp_tree = upd_tree;
  end

  // Lock exclusion; a fully locked set falls back to plain PLRU.
  always_comb begin
`ifdef LRU_WAY_LOCK_EN
    all_locked_d = &lock_mask;
    excl_eff     = all_locked_d ? '0 : lock_mask;
`else
    all_locked_d = 1'b0;
    excl_eff     = '0;
`endif
  end

  // Lookup path: victim selection on the (possibly bypassed) tree.
  plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_lkp (
    .tree_i       (lkp_tree),
    .touch_en_i   (1'b0),
    .touch_way_i  ('0),
    .valid_i      (lkp_way_valid),
    .excl_i       (excl_eff),
    .tree_o       (unused_lkp_tree),
    .victim_idx_o (lkp_idx)
  );

  // One-hot form of the selected victim.
  always_comb begin
    victim_way_d          = '0;
    victim_way_d[lkp_idx] = 1'b1;
  end

  // Tree storage: only a non-empty update writes its set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trees_q <= '{default: '0};
    end else if (upd_valid && (|upd_way)) begin
      trees_q[upd_set] <= upd_tree;
    end
  end

  // Victim output registers: pulse valid, hold data between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_idx_q   <= '0;
      all_locked_q   <= 1'b0;
    end else begin
      victim_valid_q <= lkp_valid;
      if (lkp_valid) begin
        victim_way_q <= victim_way_d;
        victim_idx_q <= lkp_idx;
        all_locked_q <= all_locked_d;
      end
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign victim_idx   = victim_idx_q;
`ifdef LRU_WAY_LOCK_EN
  assign all_locked   = all_locked_q;
`else
  logic unused_all_locked;
  assign unused_all_locked = all_locked_q;
`endif

endmodule
